add_round_key_serial: RTL and testbench
=======================================

Name: add_round_key_serial

Overview:
- Byte-serial AddRoundKey stage; sits directly downstream of the key expansion round stages.
- Collects one 16-byte cipher state block and one 16-byte round key block, each arriving as its own byte stream in any interleaving.
- Once both blocks are complete, emits state XOR key as a 16-byte serial stream.
- Pulses round_done when the block is finished; this pulse drives the next key expansion stage's round_complete input.

Parameters:
- DATA_W, 8, byte width. Fixed at 8.
- BLOCK_BYTES, 16, bytes per block. Fixed at 16; counters are sized for 0..16.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- din_state  input  8  state byte; byte 0 first, column-major order.
- enable_state  input  1  din_state valid this cycle.
- din_key  input  8  round key byte, same order; connects to a key expansion stage's dout.
- enable_key  input  1  din_key valid; connects to the key expansion stage's enable_out.
- dout  output  8  result byte.
- enable_out  output  1  dout valid.
- round_done  output  1  one-cycle pulse after the last result byte.
- busy  output  1  high in OUT and DONE.
- overflow  output  1  sticky: an input byte was dropped.

Behaviour:
- Reset (async, rst=1): all outputs go to 0, including dout=8'h00. FSM goes to LOAD. Both fill counters sc and kc go to 0. Buffer contents are don't-care.
- Reset mid-operation: the output stream aborts immediately; enable_out falls asynchronously. No round_done is issued for the aborted block.
- FSM states: LOAD, OUT, DONE.
- LOAD:
  - Each edge with enable_state=1 and sc<16: state_buf[sc]<=din_state, sc<=sc+1.
  - Each edge with enable_key=1 and kc<16: key_buf[kc]<=din_key, kc<=kc+1.
  - The two streams are independent. Simultaneous valid bytes on both streams in one cycle are both captured.
  - A byte arriving on a stream whose counter is already 16: dropped, overflow<=1. The other stream is unaffected.
  - Transition to OUT on the first edge at which sc==16 and kc==16 are both already registered. At that edge, oc<=0.
- OUT:
  - Each edge: dout<=state_buf[oc]^key_buf[oc], enable_out<=1, oc<=oc+1.
  - Exactly 16 consecutive valid cycles, bytes 0..15 in order.
  - The edge that would load oc=16 instead drives enable_out<=0, round_done<=1, next state DONE.
  - Any enable_state or enable_key seen in OUT is dropped and sets overflow. Neither buffer is modified.
- DONE:
  - Lasts one cycle; round_done is high only during it.
  - On exit: round_done<=0, sc<=0, kc<=0, next state LOAD.
  - Bytes arriving in DONE are dropped and set overflow.
- Latency: let E be the edge capturing the last outstanding byte of either stream. The counter check adds one edge (E+1, entry into OUT). The first valid dout is registered at E+2, the last at E+17, and round_done is high for the cycle after E+17.
- dout holds its last value while enable_out=0. Consumers must qualify dout with enable_out.
- overflow clears only on rst.
- Arithmetic: pure bitwise 8-bit XOR, no carries.
- busy = (state==OUT) || (state==DONE).

Test Plan:
- Sequential load: state bytes 8'h00..8'h0F, then key bytes all 8'hFF, one per cycle → after the final capture (E), dout = 8'hFF,8'hFE,…,8'hF0 on 16 consecutive cycles starting at edge E+2; round_done high one cycle after; overflow=0.
- Simultaneous streams: state byte i = 8'h32,8'h43,8'hF6,8'hA8,8'h88,8'h5A,8'h30,8'h8D,8'h31,8'h31,8'h98,8'hA2,8'hE0,8'h37,8'h07,8'h34; key byte i = 8'h2B,8'h7E,8'h15,8'h16,8'h28,8'hAE,8'hD2,8'hA6,8'hAB,8'hF7,8'h15,8'h88,8'h09,8'hCF,8'h4F,8'h3C; both presented in the same 16 cycles → dout 8'h19,8'h3D,8'hE3,8'hBE,8'hA0,8'hF4,8'hE2,8'h2B,8'h9A,8'hC6,8'h8D,8'h2A,8'hE9,8'hF8,8'h48,8'h08.
- Gapped, interleaved arrival: key bytes every third cycle, state bytes in bursts → output timing is keyed to the last capture only, values per byte index; no output before both blocks are complete.
- Overflow: a 17th state byte arrives while the key block is incomplete → byte dropped, overflow=1 and stays 1; the output uses the first 16 state bytes. Also a byte presented during OUT → dropped, overflow set, output values unchanged.
- Reset mid-output: assert rst after 5 output bytes → enable_out=0 immediately, no round_done; a fresh load after reset produces the correct full 16-byte result.
- Back-to-back blocks: a second state/key pair is sent starting the cycle after round_done → accepted without loss; round_done pulses once per block.

Source files
------------

// File: rtl/add_round_key_serial_if.sv
// Byte-stream bundle for the serial AddRoundKey stage: two input streams, one result stream
// plus status.
interface add_round_key_serial_if #(
  parameter int unsigned DATA_W = 8
);
  logic [DATA_W-1:0] din_state;
  logic              enable_state;
  logic [DATA_W-1:0] din_key;
  logic              enable_key;
  logic [DATA_W-1:0] dout;
  logic              enable_out;
  logic              round_done;
  logic              busy;
  logic              overflow;

  modport master (
    output din_state, enable_state, din_key, enable_key,
    input  dout, enable_out, round_done, busy, overflow
  );

  modport slave (
    input  din_state, enable_state, din_key, enable_key,
    output dout, enable_out, round_done, busy, overflow
  );
endinterface

// File: rtl/add_round_key_serial.sv
// Byte-serial AddRoundKey: buffers a 16-byte state block and a 16-byte round key block, then
// streams their XOR and pulses round_done to kick the next key expansion stage.
module add_round_key_serial #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned BLOCK_BYTES = 16
) (
  input logic                   clk,
  input logic                   rst,
  add_round_key_serial_if.slave bus
);
  localparam int unsigned CntW = $clog2(BLOCK_BYTES + 1);
  localparam int unsigned IdxW = $clog2(BLOCK_BYTES);
  localparam logic [CntW-1:0] Full = CntW'(BLOCK_BYTES);

  localparam logic [1:0] StLoad = 2'd0;
  localparam logic [1:0] StOut  = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  logic [1:0]        st_q, st_d;
  logic [CntW-1:0]   sc_q, sc_d, kc_q, kc_d, oc_q, oc_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              en_out_q, en_out_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;
  logic              state_wr, key_wr;

  logic [DATA_W-1:0] state_buf [BLOCK_BYTES];
  logic [DATA_W-1:0] key_buf   [BLOCK_BYTES];

  always_comb begin
    st_d     = st_q;
    sc_d     = sc_q;
    kc_d     = kc_q;
    oc_d     = oc_q;
    dout_d   = dout_q;
    en_out_d = en_out_q;
    done_d   = done_q;
    ovf_d    = ovf_q;
    state_wr = 1'b0;
    key_wr   = 1'b0;
    unique case (st_q)
      StLoad: begin
        // Streams fill independently; a byte on an already-full stream is lost.
        if (bus.enable_state) begin
          if (sc_q != Full) begin
            state_wr = 1'b1;
            sc_d     = sc_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (bus.enable_key) begin
          if (kc_q != Full) begin
            key_wr = 1'b1;
            kc_d   = kc_q + CntW'(1);
          end else begin
            ovf_d = 1'b1;
          end
        end
        if (sc_q == Full && kc_q == Full) begin
          st_d = StOut;
          oc_d = '0;
        end
      end
      StOut: begin
        if (bus.enable_state || bus.enable_key) ovf_d = 1'b1;
        if (oc_q == Full) begin
          en_out_d = 1'b0;
          done_d   = 1'b1;
          st_d     = StDone;
        end else begin
          dout_d   = state_buf[oc_q[IdxW-1:0]] ^ key_buf[oc_q[IdxW-1:0]];
          en_out_d = 1'b1;
          oc_d     = oc_q + CntW'(1);
        end
      end
      StDone: begin
        if (bus.enable_state || bus.enable_key) ovf_d = 1'b1;
        done_d = 1'b0;
        sc_d   = '0;
        kc_d   = '0;
        st_d   = StLoad;
      end
      default: st_d = StLoad;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q     <= StLoad;
      sc_q     <= '0;
      kc_q     <= '0;
      oc_q     <= '0;
      dout_q   <= '0;
      en_out_q <= 1'b0;
      done_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      st_q     <= st_d;
      sc_q     <= sc_d;
      kc_q     <= kc_d;
      oc_q     <= oc_d;
      dout_q   <= dout_d;
      en_out_q <= en_out_d;
      done_q   <= done_d;
      ovf_q    <= ovf_d;
    end
  end

  // Buffer contents need no reset: they are only read after a full refill.
  always_ff @(posedge clk) begin
    if (state_wr) state_buf[sc_q[IdxW-1:0]] <= bus.din_state;
    if (key_wr)   key_buf[kc_q[IdxW-1:0]]   <= bus.din_key;
  end

  assign bus.dout       = dout_q;
  assign bus.enable_out = en_out_q;
  assign bus.round_done = done_q;
  assign bus.overflow   = ovf_q;
  assign bus.busy       = (st_q == StOut) || (st_q == StDone);
endmodule

// File: tb/tb_add_round_key_serial.sv
// Scoreboard bench for add_round_key_serial: expected XOR bytes are queued at stimulus time
// and popped as result bytes appear.
module tb_add_round_key_serial;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;

  add_round_key_serial_if bus ();

  add_round_key_serial dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] exp_q [$];
  int out_idx   = 0;
  int first_cyc = -1;
  int done_cnt  = 0;
  int e_cyc     = 0;
  logic exp_ovf = 1'b0;

  logic [7:0] seq_s [16];
  logic [7:0] ff_k  [16];
  logic [7:0] rnd_s [16];
  logic [7:0] rnd_k [16];
  logic [7:0] aes_s [16] = '{8'h32, 8'h43, 8'hF6, 8'hA8, 8'h88, 8'h5A, 8'h30, 8'h8D,
                             8'h31, 8'h31, 8'h98, 8'hA2, 8'hE0, 8'h37, 8'h07, 8'h34};
  logic [7:0] aes_k [16] = '{8'h2B, 8'h7E, 8'h15, 8'h16, 8'h28, 8'hAE, 8'hD2, 8'hA6,
                             8'hAB, 8'hF7, 8'h15, 8'h88, 8'h09, 8'hCF, 8'h4F, 8'h3C};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    logic [7:0] e;
    if (bus.enable_out) begin
      if (out_idx == 0) first_cyc = cyc;
      out_idx++;
      if (exp_q.size() == 0) begin
        check("extra_out", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("dout", {24'd0, bus.dout}, {24'd0, e});
      end
    end
    if (bus.round_done) begin
      done_cnt++;
      out_idx = 0;
    end
  end

  // mode 0: state then key; 1: simultaneous; 2: gapped interleave; 3: 17 state bytes then key
  task automatic drive_block(input logic [7:0] s [16], input logic [7:0] k [16],
                             input int mode);
    int si, ki, t, ns;
    logic es, ek;
    ns = (mode == 3) ? 17 : 16;
    si = 0;
    ki = 0;
    t  = 0;
    first_cyc = -1;
    for (int i = 0; i < 16; i++) exp_q.push_back(s[i] ^ k[i]);
    while (si < ns || ki < 16) begin
      @(negedge clk);
      case (mode)
        1:       begin es = (si < ns); ek = (ki < 16); end
        2:       begin es = (si < ns) && (t % 7 < 3); ek = (ki < 16) && (t % 3 == 0); end
        default: begin es = (si < ns); ek = (si >= ns) && (ki < 16); end
      endcase
      bus.enable_state = es;
      bus.din_state    = (si < 16) ? s[si % 16] : 8'hEE;
      bus.enable_key   = ek;
      bus.din_key      = k[ki % 16];
      if (es) si++;
      if (ek) ki++;
      t++;
    end
    @(posedge clk);
    #1;
    e_cyc            = cyc;
    bus.enable_state = 1'b0;
    bus.enable_key   = 1'b0;
    check("no_early_out", out_idx, 0);
    check("busy_at_last_capture", {31'd0, bus.busy}, 0);
  endtask

  task automatic finish_block(input string tag, input bit inject);
    int prev;
    int rd_cyc;
    bit seen;
    prev   = done_cnt;
    rd_cyc = 0;
    seen   = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk);
      #1;
      bus.enable_state = 1'b0;
      bus.enable_key   = 1'b0;
      if (inject && cyc == e_cyc + 6) begin
        bus.din_state    = 8'h5A;
        bus.din_key      = 8'hA5;
        bus.enable_state = 1'b1;
        bus.enable_key   = 1'b1;
        exp_ovf          = 1'b1;
      end
      if (bus.round_done) begin
        seen   = 1'b1;
        rd_cyc = cyc;
      end
    end
    check({tag, "_done_seen"}, {31'd0, seen}, 1);
    check({tag, "_first_lat"}, first_cyc - e_cyc, 2);
    check({tag, "_done_lat"}, rd_cyc - e_cyc, 18);
    check({tag, "_en_low_at_done"}, {31'd0, bus.enable_out}, 0);
    check({tag, "_busy_in_done"}, {31'd0, bus.busy}, 1);
    check({tag, "_drained"}, exp_q.size(), 0);
    @(posedge clk);
    #1;
    check({tag, "_done_one_cycle"}, {31'd0, bus.round_done}, 0);
    check({tag, "_busy_after"}, {31'd0, bus.busy}, 0);
    check({tag, "_done_count"}, done_cnt - prev, 1);
    check({tag, "_overflow"}, {31'd0, bus.overflow}, {31'd0, exp_ovf});
  endtask

  initial begin
    int prev;
    bus.din_state    = '0;
    bus.enable_state = 1'b0;
    bus.din_key      = '0;
    bus.enable_key   = 1'b0;
    for (int i = 0; i < 16; i++) begin
      seq_s[i] = 8'(i);
      ff_k[i]  = 8'hFF;
      rnd_s[i] = 8'($urandom_range(0, 255));
      rnd_k[i] = 8'($urandom_range(0, 255));
    end

    #12;
    check("rst_dout", {24'd0, bus.dout}, 0);
    check("rst_enable_out", {31'd0, bus.enable_out}, 0);
    check("rst_round_done", {31'd0, bus.round_done}, 0);
    check("rst_busy", {31'd0, bus.busy}, 0);
    check("rst_overflow", {31'd0, bus.overflow}, 0);
    @(negedge clk);
    rst = 1'b0;

    drive_block(seq_s, ff_k, 0);
    finish_block("seq", 1'b0);
    drive_block(aes_s, aes_k, 1);
    finish_block("simul", 1'b0);
    drive_block(rnd_s, rnd_k, 2);
    finish_block("gapped", 1'b0);
    // Back-to-back: next block starts the cycle after the round_done cycle.
    drive_block(rnd_k, aes_s, 1);
    finish_block("b2b_a", 1'b0);
    drive_block(seq_s, aes_k, 0);
    finish_block("b2b_b", 1'b0);
    drive_block(aes_s, rnd_k, 1);
    finish_block("out_inject", 1'b1);

    drive_block(aes_s, aes_k, 1);
    for (int i = 0; i < 40 && out_idx < 5; i++) begin
      @(posedge clk);
      #1;
    end
    check("rst_mid_reached5", {31'd0, out_idx >= 5}, 1);
    check("rst_mid_pre_en", {31'd0, bus.enable_out}, 1);
    prev = done_cnt;
    rst  = 1'b1;
    #1;
    check("rst_mid_enable_out", {31'd0, bus.enable_out}, 0);
    check("rst_mid_dout", {24'd0, bus.dout}, 0);
    check("rst_mid_busy", {31'd0, bus.busy}, 0);
    check("rst_mid_overflow", {31'd0, bus.overflow}, 0);
    exp_q.delete();
    out_idx = 0;
    exp_ovf = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    repeat (25) @(posedge clk);
    #1;
    check("rst_mid_no_done", done_cnt, prev);

    drive_block(seq_s, rnd_k, 3);
    exp_ovf = 1'b1;
    check("ovf17_set", {31'd0, bus.overflow}, 1);
    finish_block("ovf17", 1'b0);
    repeat (3) @(posedge clk);
    #1;
    check("ovf_sticky", {31'd0, bus.overflow}, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation timeout, got no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
